// File: rtl/rsa_seq_pkg.sv
// Shared definitions for the RSA modexp sequencer: state encoding, default
// hold/timeout lengths, counter widths and the key-size to word-count decode.
// No ports; imported by rsa_seq_timer and rsa_modexp_sequencer.
package rsa_seq_pkg;

  localparam int DEF_GET_T_CYCLES = 10;
  localparam int DEF_START_CYCLES = 100;
  localparam int DEF_TIMEOUT      = 1 << 24;

  localparam int CNT_W = 7;   // word count / index register width
  localparam int TMR_W = 32;  // interval timer width, covers DEF_TIMEOUT

  typedef enum logic [3:0] {
    IDLE, LOAD_E, LOAD_M, LOAD_N, LOAD_NP, GAP, GET_T, WAIT_CFG,
    COMPUTE, WAIT_RD, RD_REQ, RD_CAP, RD_OUT, DONE
  } state_t;

  // Operand length in words for each RSA_Mode value; reserved codes map to 4096-bit.
  function automatic logic [CNT_W-1:0] mode_words(input logic [2:0] mode);
    case (mode)
      3'd0:    mode_words = 7'd6;
      3'd1:    mode_words = 7'd8;
      3'd2:    mode_words = 7'd16;
      3'd3:    mode_words = 7'd32;
      default: mode_words = 7'd64;
    endcase
  endfunction

endpackage

// File: rtl/rsa_seq_timer.sv
// Loadable down-counter: i_load sets the count, it then decrements to zero and
// holds; o_expired is high while the count is zero. Latency: load visible next cycle.
// Ports: i_clk, i_reset (sync, active-high), i_load, i_load_val, o_expired. No backpressure.
module rsa_seq_timer
  import rsa_seq_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/rsa_modexp_sequencer.sv
// Host-stream front end for the RSA modexp core: loads exponent, message, modulus
// and nprime0, runs the get_t/startCompute/getResult handshake, then streams results.
// Latency: core valid one cycle after each operand beat; >=3 cycles per result word.
// Backpressure: in_ready only in load states; res_data/res_last hold while res_ready=0.
// Ports: i_clk/i_reset, i_start/i_rsa_mode/o_busy/o_done/o_err control, i_in_* operand
// stream, o_{ex,msg,modn,np0}_* core loads, o_core_mode, o_get_t/i_cfg_done,
// o_start_compute/o_get_result/i_wait_read, o_read_en/o_read_addr/i_outp, o_res_* stream.
module rsa_modexp_sequencer
  import rsa_seq_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int MAX_WORDS    = 64,
  parameter int GET_T_CYCLES = DEF_GET_T_CYCLES,
  parameter int START_CYCLES = DEF_START_CYCLES,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [2:0]            i_rsa_mode,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  output logic                  o_ex_valid,
  output logic [DATA_WIDTH-1:0] o_ex_data,
  output logic                  o_msg_valid,
  output logic [DATA_WIDTH-1:0] o_msg_data,
  output logic                  o_modn_valid,
  output logic [DATA_WIDTH-1:0] o_modn_data,
  output logic                  o_np0_valid,
  output logic [DATA_WIDTH-1:0] o_np0_data,
  output logic [4:0]            o_core_mode,
  output logic                  o_get_t,
  input  logic                  i_cfg_done,
  output logic                  o_start_compute,
  output logic                  o_get_result,
  input  logic                  i_wait_read,
  output logic                  o_read_en,
  output logic [31:0]           o_read_addr,
  input  logic [DATA_WIDTH-1:0] i_outp,
  output logic                  o_res_valid,
  input  logic                  i_res_ready,
  output logic [DATA_WIDTH-1:0] o_res_data,
  output logic                  o_res_last
);

  state_t                r_state, w_state_nxt;
  logic [2:0]            r_mode;
  logic [CNT_W-1:0]      r_n, r_cnt, w_n_dec;
  logic [1:0]            r_grp;       // operand group just finished, steers GAP
  logic [DATA_WIDTH-1:0] r_core_dat;  // only one core valid is ever high, so one data reg serves all four
  logic [DATA_WIDTH-1:0] r_res_data;
  logic r_ex_vld, r_msg_vld, r_modn_vld, r_np0_vld;
  logic r_get_result, r_err, r_cfg_prev, r_rd_prev;
  logic w_loading, w_beat, w_grp_last, w_idx_last, w_cfg_rise, w_rd_rise, w_timeout;
  logic w_tmr_load, w_tmr_exp;
  logic [TMR_W-1:0] w_tmr_val;

  assign w_n_dec    = (mode_words(i_rsa_mode) > CNT_W'(MAX_WORDS)) ? CNT_W'(MAX_WORDS)
                                                                    : mode_words(i_rsa_mode);
  assign w_loading  = (r_state == LOAD_E) || (r_state == LOAD_M) ||
                      (r_state == LOAD_N) || (r_state == LOAD_NP);
  assign w_beat     = w_loading && i_in_valid;
  assign w_grp_last = (r_state == LOAD_NP) || (r_cnt == r_n - CNT_W'(1));
  assign w_idx_last = (r_cnt == r_n - CNT_W'(1));
  // Edge detection against the previous sample: a level already high does not count.
  assign w_cfg_rise = i_cfg_done && !r_cfg_prev;
  assign w_rd_rise  = i_wait_read && !r_rd_prev;

  rsa_seq_timer #(.W(TMR_W)) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_expired  (w_tmr_exp)
  );

  // Timer is loaded with (length-1) on entry so a state lasts exactly 'length' cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE:    if (i_start) w_state_nxt = LOAD_E;
      LOAD_E, LOAD_M, LOAD_N, LOAD_NP:
               if (w_beat && w_grp_last) w_state_nxt = GAP;
      GAP: begin
        case (r_grp)
          2'd0:    w_state_nxt = LOAD_M;
          2'd1:    w_state_nxt = LOAD_N;
          2'd2:    w_state_nxt = LOAD_NP;
          default: begin
            w_state_nxt = GET_T;
            w_tmr_load  = 1'b1;
            w_tmr_val   = TMR_W'(GET_T_CYCLES - 1);
          end
        endcase
      end
      GET_T: if (w_tmr_exp) begin
        w_state_nxt = WAIT_CFG;
        w_tmr_load  = 1'b1;
        w_tmr_val   = TMR_W'(TIMEOUT - 1);
      end
      WAIT_CFG: begin
        if (w_cfg_rise) begin
          w_state_nxt = COMPUTE;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TMR_W'(START_CYCLES - 1);
        end else if (w_tmr_exp) begin
          w_state_nxt = IDLE;
          w_timeout   = 1'b1;
        end
      end
      COMPUTE: if (w_tmr_exp) begin
        w_state_nxt = WAIT_RD;
        w_tmr_load  = 1'b1;
        w_tmr_val   = TMR_W'(TIMEOUT - 1);
      end
      WAIT_RD: begin
        if (w_rd_rise) begin
          w_state_nxt = RD_REQ;
        end else if (w_tmr_exp) begin
          w_state_nxt = IDLE;
          w_timeout   = 1'b1;
        end
      end
      RD_REQ:  w_state_nxt = RD_CAP;
      RD_CAP:  w_state_nxt = RD_OUT;
      RD_OUT:  if (i_res_ready) w_state_nxt = w_idx_last ? DONE : RD_REQ;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_mode       <= '0;
      r_n          <= '0;
      r_cnt        <= '0;
      r_grp        <= '0;
      r_core_dat   <= '0;
      r_res_data   <= '0;
      r_ex_vld     <= 1'b0;
      r_msg_vld    <= 1'b0;
      r_modn_vld   <= 1'b0;
      r_np0_vld    <= 1'b0;
      r_get_result <= 1'b0;
      r_err        <= 1'b0;
      r_cfg_prev   <= 1'b0;
      r_rd_prev    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cfg_prev <= i_cfg_done;
      r_rd_prev  <= i_wait_read;
      r_err      <= w_timeout;
      r_ex_vld   <= w_beat && (r_state == LOAD_E);
      r_msg_vld  <= w_beat && (r_state == LOAD_M);
      r_modn_vld <= w_beat && (r_state == LOAD_N);
      r_np0_vld  <= w_beat && (r_state == LOAD_NP);
      if (w_beat) r_core_dat <= i_in_data;
      case (r_state)
        IDLE: if (i_start) begin
          r_mode <= i_rsa_mode;
          r_n    <= w_n_dec;
          r_cnt  <= '0;
          r_grp  <= '0;
        end
        LOAD_E, LOAD_M, LOAD_N, LOAD_NP:
          if (w_beat) r_cnt <= w_grp_last ? '0 : r_cnt + CNT_W'(1);
        GAP:     r_grp <= r_grp + 2'd1;
        COMPUTE: if (w_tmr_exp) r_get_result <= 1'b1;  // rises as start_compute falls
        WAIT_RD: if (w_rd_rise) r_cnt <= '0;
        RD_CAP:  r_res_data <= i_outp;
        RD_OUT:  if (i_res_ready && !w_idx_last) r_cnt <= r_cnt + CNT_W'(1);
        default: ;
      endcase
      if (w_state_nxt == IDLE || w_state_nxt == DONE) r_get_result <= 1'b0;
    end
  end

  assign o_busy          = (r_state != IDLE) && (r_state != DONE);
  assign o_done          = (r_state == DONE);
  assign o_err           = r_err;
  assign o_in_ready      = w_loading;
  assign o_ex_valid      = r_ex_vld;
  assign o_msg_valid     = r_msg_vld;
  assign o_modn_valid    = r_modn_vld;
  assign o_np0_valid     = r_np0_vld;
  assign o_ex_data       = r_core_dat;
  assign o_msg_data      = r_core_dat;
  assign o_modn_data     = r_core_dat;
  assign o_np0_data      = r_core_dat;
  assign o_core_mode     = {2'b00, r_mode};
  assign o_get_t         = (r_state == GET_T);
  assign o_start_compute = (r_state == COMPUTE);
  assign o_get_result    = r_get_result;
  assign o_read_en       = (r_state == RD_REQ);
  assign o_read_addr     = (r_state == RD_REQ) ? 32'(r_cnt) : 32'd0;
  assign o_res_valid     = (r_state == RD_OUT);
  assign o_res_data      = r_res_data;
  assign o_res_last      = (r_state == RD_OUT) && w_idx_last;

endmodule

// File: tb/tb_rsa_modexp_sequencer.sv
module tb_rsa_modexp_sequencer;

  localparam int DW = 64;
  localparam int TO = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, in_valid, res_ready;
  logic [2:0]    rsa_mode;
  logic [DW-1:0] in_data;
  logic          cfg_done = 1'b0, wait_read = 1'b0;
  logic [DW-1:0] outp = '0;
  logic          busy, done, err, in_ready, ex_valid, msg_valid, modn_valid, np0_valid;
  logic [DW-1:0] ex_data, msg_data, modn_data, np0_data, res_data;
  logic [4:0]    core_mode;
  logic          get_t, start_compute, get_result, read_en, res_valid, res_last;
  logic [31:0]   read_addr;

  rsa_modexp_sequencer #(
    .DATA_WIDTH(DW), .MAX_WORDS(64), .GET_T_CYCLES(10), .START_CYCLES(100), .TIMEOUT(TO)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_rsa_mode(rsa_mode),
    .o_busy(busy), .o_done(done), .o_err(err),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_ex_valid(ex_valid), .o_ex_data(ex_data), .o_msg_valid(msg_valid), .o_msg_data(msg_data),
    .o_modn_valid(modn_valid), .o_modn_data(modn_data), .o_np0_valid(np0_valid), .o_np0_data(np0_data),
    .o_core_mode(core_mode), .o_get_t(get_t), .i_cfg_done(cfg_done),
    .o_start_compute(start_compute), .o_get_result(get_result), .i_wait_read(wait_read),
    .o_read_en(read_en), .o_read_addr(read_addr), .i_outp(outp),
    .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_data(res_data), .o_res_last(res_last)
  );

  // Behavioural core: Config_Done 20 cycles after get_t falls, wait_read 50 cycles
  // after startCompute falls, result memory returned the cycle after read_en.
  logic [DW-1:0] stub_mem [64];
  bit stub_cfg_en = 1'b1;
  int cfg_dly = 0, cfg_hold = 0, rd_dly = 0, rd_hold = 0;
  logic gt_prev = 1'b0, sc_prev = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      cfg_done = 1'b0; wait_read = 1'b0; outp = '0;
      cfg_dly = 0; cfg_hold = 0; rd_dly = 0; rd_hold = 0; gt_prev = 1'b0; sc_prev = 1'b0;
    end else begin
      if (gt_prev && !get_t && stub_cfg_en) cfg_dly = 20;
      else if (cfg_dly > 0) begin
        cfg_dly--;
        if (cfg_dly == 0) begin cfg_done = 1'b1; cfg_hold = 3; end
      end else if (cfg_hold > 0) begin
        cfg_hold--;
        if (cfg_hold == 0) cfg_done = 1'b0;
      end
      if (sc_prev && !start_compute) rd_dly = 50;
      else if (rd_dly > 0) begin
        rd_dly--;
        if (rd_dly == 0) begin wait_read = 1'b1; rd_hold = 3; end
      end else if (rd_hold > 0) begin
        rd_hold--;
        if (rd_hold == 0) wait_read = 1'b0;
      end
      if (read_en) outp = stub_mem[read_addr[5:0]];
      gt_prev = get_t;
      sc_prev = start_compute;
    end
  end

  int n_tests, n_fail, cyc;
  int j_done, j_err, j_readen, j_multi, j_unstable, j_res_bad, j_res_cnt, j_last_bad, j_beat_bad;
  int j_beat_cnt[4], j_first[4], j_last[4];
  int j_gt_runs[$], j_sc_runs[$];
  int j_gt_fall, j_sc_fall, j_gr_rise, j_err_cyc;
  logic j_busy_at_err, j_gr_at_err;
  logic [4:0] j_core_mode;

  function automatic int nwords(input logic [2:0] m);
    case (m)
      3'd0: return 6;
      3'd1: return 8;
      3'd2: return 16;
      3'd3: return 32;
      default: return 64;
    endcase
  endfunction

  function automatic logic any_out();
    return |{busy, done, err, in_ready, ex_valid, msg_valid, modn_valid, np0_valid,
             ex_data, msg_data, modn_data, np0_data, core_mode, get_t, start_compute,
             get_result, read_en, read_addr, res_valid, res_data, res_last};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input logic [2:0] mode, input bit toggle, input int stall,
                         input bit extra, input int abort_beat);
    int n, pi, ri, k, wait_cnt, gt_run, sc_run, nv, g, eg;
    bit pend, gr_prev, want, start_now;
    logic [DW-1:0] held_d, d;
    logic held_l;
    logic [DW-1:0] words[$];
    n = nwords(mode);
    words = {};
    for (int i = 0; i < 3*n+1; i++) words.push_back({$urandom, $urandom});
    j_done = 0; j_err = 0; j_readen = 0; j_multi = 0; j_unstable = 0; j_res_bad = 0;
    j_res_cnt = 0; j_last_bad = 0; j_beat_bad = 0; j_gt_runs = {}; j_sc_runs = {};
    j_gt_fall = -1; j_sc_fall = -1; j_gr_rise = -2; j_err_cyc = -1;
    j_busy_at_err = 1'bx; j_gr_at_err = 1'bx; j_core_mode = 5'h1f;
    for (int i = 0; i < 4; i++) begin j_beat_cnt[i] = 0; j_first[i] = -1; j_last[i] = -1; end
    pi = 0; ri = 0; k = 0; wait_cnt = 0; gt_run = 0; sc_run = 0; pend = 0; gr_prev = 0;
    held_d = '0; held_l = 1'b0;
    @(negedge clk); cyc++;
    rsa_mode = mode; start = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk); cyc++;
      start_now = 0;
      // observe core-side operand beats against the expected word order
      nv = int'(ex_valid) + int'(msg_valid) + int'(modn_valid) + int'(np0_valid);
      if (nv > 1) j_multi++;
      if (nv == 1) begin
        g = ex_valid ? 0 : msg_valid ? 1 : modn_valid ? 2 : 3;
        d = ex_valid ? ex_data : msg_valid ? msg_data : modn_valid ? modn_data : np0_data;
        eg = (k < 3*n) ? k / n : 3;
        j_beat_cnt[g]++;
        if (j_first[g] < 0) j_first[g] = cyc;
        j_last[g] = cyc;
        if (k >= words.size() || d !== words[k] || g != eg) j_beat_bad++;
        k++;
      end
      if (get_t) gt_run++;
      else if (gt_run > 0) begin j_gt_runs.push_back(gt_run); gt_run = 0; j_gt_fall = cyc; end
      if (start_compute) sc_run++;
      else if (sc_run > 0) begin j_sc_runs.push_back(sc_run); sc_run = 0; j_sc_fall = cyc; end
      if (get_result && !gr_prev) j_gr_rise = cyc;
      gr_prev = get_result;
      if (read_en) j_readen++;
      if (err) begin
        j_err++; j_err_cyc = cyc; j_busy_at_err = busy; j_gr_at_err = get_result;
        break;
      end
      if (done) begin j_done++; j_core_mode = core_mode; break; end
      // result sink with per-word stall
      if (res_valid) begin
        if (!pend) begin
          pend = 1; held_d = res_data; held_l = res_last; wait_cnt = 0;
          if (extra && ri == 2) start_now = 1;
        end else if (res_data !== held_d || res_last !== held_l) j_unstable++;
      end
      res_ready = pend && (wait_cnt >= stall);
      if (pend && !res_ready) wait_cnt++;
      if (res_valid && res_ready) begin
        if (ri >= 64 || res_data !== stub_mem[ri]) j_res_bad++;
        if (res_last !== 1'(ri == n-1)) j_last_bad++;
        ri++; pend = 0; j_res_cnt++;
      end
      // operand source
      if (abort_beat >= 0 && pi == abort_beat) begin
        reset = 1'b1; in_valid = 1'b0; start = 1'b0; res_ready = 1'b0;
        break;
      end
      want = !toggle || (cyc % 2 == 0);
      in_valid = 1'b0;
      if (pi < words.size() && want) begin
        in_valid = 1'b1; in_data = words[pi];
        if (in_ready) begin
          pi++;
          if (extra && pi == n+1) start_now = 1;
        end
      end
      start = start_now;
      rsa_mode = 3'($urandom);
    end
    in_valid = 1'b0; res_ready = 1'b0; start = 1'b0;
  endtask

  task automatic check_job(input string tag, input logic [2:0] mode, input bit exact_gap);
    int n;
    n = nwords(mode);
    chk({tag, "_done"}, j_done, 1);
    chk({tag, "_err"}, j_err, 0);
    for (int g = 0; g < 4; g++) chk($sformatf("%s_beats%0d", tag, g), j_beat_cnt[g], (g == 3) ? 1 : n);
    chk({tag, "_beat_data"}, j_beat_bad, 0);
    chk({tag, "_multi_valid"}, j_multi, 0);
    chk({tag, "_get_t_len"}, (j_gt_runs.size() == 1) ? j_gt_runs[0] : -1, 10);
    chk({tag, "_start_len"}, (j_sc_runs.size() == 1) ? j_sc_runs[0] : -1, 100);
    chk({tag, "_get_result_rise"}, j_gr_rise, j_sc_fall);
    chk({tag, "_res_count"}, j_res_cnt, n);
    chk({tag, "_res_data"}, j_res_bad, 0);
    chk({tag, "_res_last"}, j_last_bad, 0);
    chk({tag, "_res_stable"}, j_unstable, 0);
    chk({tag, "_read_en"}, j_readen, n);
    chk({tag, "_core_mode"}, j_core_mode, {2'b00, mode});
    if (exact_gap)
      for (int g = 0; g < 3; g++) chk($sformatf("%s_gap%0d", tag, g), j_first[g+1] - j_last[g], 2);
  endtask

  initial begin
    logic [2:0] rm;
    n_tests = 0; n_fail = 0; cyc = 0;
    reset = 1'b1; start = 1'b0; rsa_mode = '0; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    for (int i = 0; i < 64; i++) stub_mem[i] = {$urandom, 32'hA0 + i};
    repeat (3) @(negedge clk);
    chk("reset_outputs", any_out(), 0);
    reset = 1'b0;

    run_job(3'd0, 0, 0, 0, -1);
    check_job("m0", 3'd0, 1);

    run_job(3'd4, 1, 5, 0, -1);
    check_job("m4_stall", 3'd4, 0);

    stub_cfg_en = 1'b0;
    run_job(3'd0, 0, 0, 0, -1);
    chk("to_err", j_err, 1);
    chk("to_done", j_done, 0);
    chk("to_latency", j_err_cyc - j_gt_fall, TO);
    chk("to_busy", j_busy_at_err, 0);
    chk("to_get_result", j_gr_at_err, 0);
    chk("to_read_en", j_readen, 0);
    @(negedge clk); cyc++;
    chk("to_err_pulse", err, 0);
    stub_cfg_en = 1'b1;

    run_job(3'd2, 0, 2, 1, -1);
    check_job("m2_restart", 3'd2, 1);

    run_job(3'd2, 0, 0, 0, 2*16 + 3);
    @(negedge clk); cyc++;
    chk("abort_outputs", any_out(), 0);
    reset = 1'b0;
    run_job(3'd1, 0, 1, 0, -1);
    check_job("m1_after_abort", 3'd1, 1);

    run_job(3'd7, 0, 0, 0, -1);
    check_job("m7", 3'd7, 1);

    rm = 3'($urandom_range(0, 7));
    run_job(rm, 1, $urandom_range(0, 3), 0, -1);
    check_job("mrand", rm, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
